// File: rtl/riscv_definitions.sv
// rtl/riscv_definitions.sv - shared RISC-V enums and bus unions for the memory port
package riscv_definitions;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_WAIT = 2'd1,
    DM_WAIT = 2'd2
  } memCtrlState_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } memOwner_e;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } funct3ITypeLOAD_e;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } funct3SType_e;

  typedef union packed {
    logic [31:0]      word;
    logic [1:0][15:0] halves;
    logic [3:0][7:0]  bytes;
  } dataBus_u;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } rType_t;

  typedef union packed {
    logic [31:0] raw;
    rType_t      r;
  } instruction_u;

endpackage

// File: rtl/mem_port_arbiter_lsu_lane_align.sv
// rtl/mem_port_arbiter_lsu_lane_align.sv - lane steering, load extension and access legality
module lsu_lane_align
  import riscv_definitions::*;
(
  input  logic       i_req_we,
  input  logic [2:0] i_req_funct3,
  input  logic [1:0] i_req_off,
  input  dataBus_u   i_req_wdata,
  output logic [3:0] o_be,
  output dataBus_u   o_wdata,
  output logic       o_err,
  input  logic       i_rsp_we,
  input  logic [2:0] i_rsp_funct3,
  input  logic [1:0] i_rsp_off,
  input  dataBus_u   i_rsp_rdata,
  output dataBus_u   o_rsp_data
);

  logic [31:0] w_shifted;

  assign w_shifted = i_rsp_rdata.word >> {i_rsp_off, 3'b000};

  always_comb begin
    o_be    = 4'hF;
    o_wdata = '0;
    o_err   = 1'b0;
    if (i_req_we) begin
      case (funct3SType_e'(i_req_funct3))
        SB: begin
          o_be         = 4'b0001 << i_req_off;
          o_wdata.word = {4{i_req_wdata.bytes[0]}};
        end
        SH: begin
          o_be         = 4'b0011 << i_req_off;
          o_wdata.word = {2{i_req_wdata.halves[0]}};
          o_err        = i_req_off[0];
        end
        SW: begin
          o_wdata = i_req_wdata;
          o_err   = |i_req_off;
        end
        default: o_err = 1'b1;
      endcase
    end else begin
      case (funct3ITypeLOAD_e'(i_req_funct3))
        LB, LBU: o_err = 1'b0;
        LH, LHU: o_err = i_req_off[0];
        LW:      o_err = |i_req_off;
        default: o_err = 1'b1;
      endcase
    end
  end

  // Stores acknowledge with zero data; loads pick their lane then extend.
  always_comb begin
    o_rsp_data = '0;
    if (!i_rsp_we) begin
      case (funct3ITypeLOAD_e'(i_rsp_funct3))
        LB:      o_rsp_data.word = {{24{w_shifted[7]}}, w_shifted[7:0]};
        LBU:     o_rsp_data.word = {24'h0, w_shifted[7:0]};
        LH:      o_rsp_data.word = {{16{w_shifted[15]}}, w_shifted[15:0]};
        LHU:     o_rsp_data.word = {16'h0, w_shifted[15:0]};
        default: o_rsp_data.word = w_shifted;
      endcase
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and load/store
// Data has priority; a starvation counter lets a waiting fetch win periodically.
module mem_port_arbiter
  import riscv_definitions::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         if_req_i,
  input  logic [31:0]  if_addr_i,
  output logic         if_gnt_o,
  output logic         if_rvalid_o,
  output instruction_u if_rdata_o,
  input  logic         dm_req_i,
  input  logic         dm_we_i,
  input  logic [2:0]   dm_funct3_i,
  input  logic [31:0]  dm_addr_i,
  input  dataBus_u     dm_wdata_i,
  output logic         dm_gnt_o,
  output logic         dm_err_o,
  output logic         dm_rvalid_o,
  output dataBus_u     dm_rdata_o,
  output logic         mem_req_o,
  output logic         mem_we_o,
  output logic [3:0]   mem_be_o,
  output logic [31:0]  mem_addr_o,
  output logic [31:0]  mem_wdata_o,
  input  logic         mem_gnt_i,
  input  logic         mem_rvalid_i,
  input  logic [31:0]  mem_rdata_i
);

  localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

  memCtrlState_e r_state;
  memOwner_e     r_owner;
  logic [3:0]    r_cnt;
  logic [2:0]    r_funct3;
  logic [1:0]    r_off;
  logic          r_we;

  logic       w_idle;
  logic       w_wait;
  logic       w_pick_dm;
  logic       w_dm_err;
  logic       w_err_cycle;
  logic       w_accept;
  logic [3:0] w_be;
  dataBus_u   w_wdata;
  dataBus_u   w_rsp_data;
  dataBus_u   w_rdata_bus;
  logic       w_unused;

  assign w_unused    = ^if_addr_i[1:0];
  assign w_idle      = rst_n && (r_state == IDLE);
  assign w_wait      = rst_n && (r_state != IDLE);
  assign w_pick_dm   = dm_req_i && !((r_cnt == LP_LIMIT) && if_req_i);
  assign w_rdata_bus = dataBus_u'(mem_rdata_i);

  lsu_lane_align u_align (
    .i_req_we     (dm_we_i),
    .i_req_funct3 (dm_funct3_i),
    .i_req_off    (dm_addr_i[1:0]),
    .i_req_wdata  (dm_wdata_i),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_err        (w_dm_err),
    .i_rsp_we     (r_we),
    .i_rsp_funct3 (r_funct3),
    .i_rsp_off    (r_off),
    .i_rsp_rdata  (w_rdata_bus),
    .o_rsp_data   (w_rsp_data)
  );

  // A rejected data access never reaches memory but still consumes the grant slot.
  assign w_err_cycle = w_idle && w_pick_dm && w_dm_err;
  assign mem_req_o   = w_idle && (w_pick_dm ? !w_dm_err : if_req_i);
  assign w_accept    = mem_req_o && mem_gnt_i;

  assign dm_gnt_o    = w_err_cycle || (w_accept && w_pick_dm);
  assign dm_err_o    = w_err_cycle;
  assign if_gnt_o    = w_accept && !w_pick_dm;

  assign mem_we_o    = mem_req_o && w_pick_dm && dm_we_i;
  assign mem_be_o    = w_pick_dm ? w_be : 4'hF;
  assign mem_addr_o  = w_pick_dm ? {dm_addr_i[31:2], 2'b00} : {if_addr_i[31:2], 2'b00};
  assign mem_wdata_o = (w_pick_dm && dm_we_i) ? w_wdata.word : 32'h0;

  assign if_rvalid_o = w_wait && (r_owner == OWN_IF) && mem_rvalid_i;
  assign dm_rvalid_o = w_wait && (r_owner == OWN_DM) && mem_rvalid_i;
  assign if_rdata_o  = if_rvalid_o ? instruction_u'(mem_rdata_i) : '0;
  assign dm_rdata_o  = dm_rvalid_o ? w_rsp_data : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_owner  <= OWN_IF;
      r_cnt    <= 4'd0;
      r_funct3 <= 3'd0;
      r_off    <= 2'd0;
      r_we     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state  <= w_pick_dm ? DM_WAIT : IF_WAIT;
            r_owner  <= w_pick_dm ? OWN_DM : OWN_IF;
            r_funct3 <= w_pick_dm ? dm_funct3_i : 3'b010;
            r_off    <= w_pick_dm ? dm_addr_i[1:0] : 2'b00;
            r_we     <= w_pick_dm && dm_we_i;
          end
        end
        IF_WAIT, DM_WAIT: begin
          if (mem_rvalid_i) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (!if_req_i || if_gnt_o) begin
        r_cnt <= 4'd0;
      end else if (dm_gnt_o && (r_cnt != LP_LIMIT)) begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized and directed bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic        if_gnt_o, if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        dm_req_i = 1'b0, dm_we_i = 1'b0;
  logic [2:0]  dm_funct3_i = '0;
  logic [31:0] dm_addr_i = '0, dm_wdata_i = '0;
  logic        dm_gnt_o, dm_err_o, dm_rvalid_o;
  logic [31:0] dm_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;

  int n_pass = 0;
  int n_total = 0;

  int          gnt_pct = 100;
  int          rsp_min = 0;
  int          rsp_max = 0;
  logic        ovr_on = 1'b0;
  logic [31:0] ovr_word = '0;

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_funct3_i(dm_funct3_i),
    .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i), .dm_gnt_o(dm_gnt_o),
    .dm_err_o(dm_err_o), .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference rules ----------------
  function automatic int op_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic access_bad(input logic we, input logic [2:0] f3, input logic [1:0] a);
    if (we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 > 3'd5)) return 1'b1;
    return (int'(a) % op_size(f3)) != 0;
  endfunction

  function automatic logic [3:0] be_of(input logic [2:0] f3, input logic [1:0] off);
    int m;
    m = ((1 << op_size(f3)) - 1) << off;
    return m[3:0];
  endfunction

  function automatic logic [31:0] lane_data(input logic [31:0] d, input logic [2:0] f3);
    logic [31:0] r;
    int sz;
    sz = op_size(f3);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % sz) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] load_value(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] off);
    logic [31:0] v;
    int sz;
    v = w >> (8 * int'(off));
    sz = op_size(f3);
    if (sz == 1) begin
      v = v & 32'hFF;
      if (f3 < 3'd4 && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 2) begin
      v = v & 32'hFFFF;
      if (f3 < 3'd4 && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  // ---------------- memory responder ----------------
  logic [31:0] mem [256];
  bit          pend = 0;
  int          rsp_wait = 0;
  logic [31:0] rsp_data = '0;
  logic [7:0]  idx;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    forever begin
      @(negedge clk);
      if (pend && mem_rvalid_i) pend = 0;
      if (rst_n && mem_req_o && mem_gnt_i) begin
        idx = mem_addr_o[9:2];
        rsp_data = ovr_on ? ovr_word : mem[idx];
        if (mem_we_o)
          for (int b = 0; b < 4; b++)
            if (mem_be_o[b]) mem[idx][8*b +: 8] = mem_wdata_o[8*b +: 8];
        pend = 1;
        rsp_wait = $urandom_range(rsp_max, rsp_min);
      end
      @(posedge clk);
      #2;
      mem_gnt_i = !pend && ($urandom_range(0, 99) < gnt_pct);
      if (pend && rsp_wait == 0) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = rsp_data;
      end else begin
        if (pend) rsp_wait--;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = $urandom;
      end
    end
  end

  // ---------------- per-cycle model compare ----------------
  int          m_busy = 0;
  int          m_cnt = 0;
  logic        m_we = 0;
  logic [2:0]  m_f3 = '0;
  logic [1:0]  m_off = '0;
  logic        e_req, e_if_gnt, e_dm_gnt, e_err, e_we, e_if_rv, e_dm_rv, dm_first;
  logic [3:0]  e_be;
  logic [31:0] e_addr, e_wd, e_rd_if, e_rd_dm;

  always @(negedge clk) begin
    e_req = 0; e_if_gnt = 0; e_dm_gnt = 0; e_err = 0; e_we = 0;
    e_if_rv = 0; e_dm_rv = 0; e_be = 4'hF; e_addr = '0; e_wd = '0;
    e_rd_if = '0; e_rd_dm = '0; dm_first = 0;
    if (!rst_n) begin
      m_busy = 0;
      m_cnt = 0;
    end else if (m_busy == 0) begin
      dm_first = dm_req_i && !(m_cnt == LIMIT && if_req_i);
      e_err    = dm_first && access_bad(dm_we_i, dm_funct3_i, dm_addr_i[1:0]);
      e_req    = dm_first ? !e_err : if_req_i;
      e_dm_gnt = dm_first && (e_err || mem_gnt_i);
      e_if_gnt = !dm_first && if_req_i && mem_gnt_i;
      e_addr   = (dm_first ? dm_addr_i : if_addr_i) & 32'hFFFF_FFFC;
      e_we     = dm_first && dm_we_i;
      e_be     = e_we ? be_of(dm_funct3_i, dm_addr_i[1:0]) : 4'hF;
      e_wd     = lane_data(dm_wdata_i, dm_funct3_i);
    end else begin
      e_if_rv = (m_busy == 1) && mem_rvalid_i;
      e_dm_rv = (m_busy == 2) && mem_rvalid_i;
      if (e_if_rv) e_rd_if = mem_rdata_i;
      if (e_dm_rv && !m_we) e_rd_dm = load_value(mem_rdata_i, m_f3, m_off);
    end

    chk("c_mem_req", mem_req_o, e_req);
    chk("c_if_gnt", if_gnt_o, e_if_gnt);
    chk("c_dm_gnt", dm_gnt_o, e_dm_gnt);
    chk("c_dm_err", dm_err_o, e_err);
    chk("c_if_rvalid", if_rvalid_o, e_if_rv);
    chk("c_dm_rvalid", dm_rvalid_o, e_dm_rv);
    chk("c_if_rdata", if_rdata_o, e_rd_if);
    chk("c_dm_rdata", dm_rdata_o, e_rd_dm);
    if (e_req) begin
      chk("c_mem_addr", mem_addr_o, e_addr);
      chk("c_mem_we", mem_we_o, e_we);
      chk("c_mem_be", mem_be_o, e_be);
      if (e_we) chk("c_mem_wdata", mem_wdata_o, e_wd);
    end

    if (rst_n) begin
      if (m_busy != 0) begin
        if (mem_rvalid_i) m_busy = 0;
      end else if (e_dm_gnt && !e_err) begin
        m_busy = 2; m_we = dm_we_i; m_f3 = dm_funct3_i; m_off = dm_addr_i[1:0];
      end else if (e_if_gnt) begin
        m_busy = 1;
      end
      if (e_if_gnt || !if_req_i) m_cnt = 0;
      else if (e_dm_gnt) m_cnt = (m_cnt < LIMIT) ? m_cnt + 1 : LIMIT;
    end
  end

  // ---------------- directed helpers ----------------
  task automatic dm_op(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       output logic err, output logic mreq, output logic [3:0] be,
                       output logic [31:0] mwd, output logic [31:0] maddr,
                       output logic [31:0] rd, output logic rv);
    bit got;
    got = 0; err = 0; mreq = 0; be = '0; mwd = '0; maddr = '0; rd = '0; rv = 0;
    dm_we_i = we; dm_funct3_i = f3; dm_addr_i = a; dm_wdata_i = wd; dm_req_i = 1'b1;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      if (dm_gnt_o) begin
        got = 1; err = dm_err_o; mreq = mem_req_o; be = mem_be_o;
        mwd = mem_wdata_o; maddr = mem_addr_o;
      end
      @(posedge clk);
      #1;
    end
    dm_req_i = 1'b0;
    chk("dm_op_granted", got, 1);
    if (got && !err)
      for (int n = 0; n < 50 && !rv; n++) begin
        @(negedge clk);
        if (dm_rvalid_o) begin
          rv = 1; rd = dm_rdata_o;
        end
        @(posedge clk);
        #1;
      end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  logic        r_err, r_mreq, r_rv, gi, gd, seen_rv;
  logic [3:0]  r_be;
  logic [31:0] r_mwd, r_maddr, r_rd;
  bit          seq [10];
  int          ns;
  bit          got;

  initial begin
    // Requests and a ready memory during reset must not leak grants.
    if_req_i = 1; dm_req_i = 1; dm_funct3_i = 3'b010; dm_addr_i = 32'h100;
    repeat (2) @(negedge clk);
    chk("rst_dm_gnt", dm_gnt_o, 0);
    chk("rst_if_gnt", if_gnt_o, 0);
    chk("rst_mem_req", mem_req_o, 0);
    @(posedge clk);
    #1;
    if_req_i = 0; dm_req_i = 0; rst_n = 1;
    @(posedge clk);
    #1;

    ovr_on = 1; ovr_word = 32'h80FF_0000;
    dm_op(0, 3'b000, 32'h1003, 0, r_err, r_mreq, r_be, r_mwd, r_maddr, r_rd, r_rv);
    chk("lb_be", r_be, 4'hF);
    chk("lb_rvalid", r_rv, 1);
    chk("lb_rdata", r_rd, 32'hFFFF_FF80);
    dm_op(0, 3'b100, 32'h1003, 0, r_err, r_mreq, r_be, r_mwd, r_maddr, r_rd, r_rv);
    chk("lbu_rdata", r_rd, 32'h0000_0080);
    ovr_on = 0;

    dm_op(1, 3'b001, 32'h2002, 32'h0000_BEEF, r_err, r_mreq, r_be, r_mwd, r_maddr, r_rd, r_rv);
    chk("sh_be", r_be, 4'b1100);
    chk("sh_wdata", r_mwd, 32'hBEEF_BEEF);
    chk("sh_addr", r_maddr, 32'h2000);
    chk("sh_ack", r_rv, 1);
    chk("sh_rdata", r_rd, 32'h0);

    dm_op(0, 3'b010, 32'h3001, 0, r_err, r_mreq, r_be, r_mwd, r_maddr, r_rd, r_rv);
    chk("lw_mis_err", r_err, 1);
    chk("lw_mis_memreq", r_mreq, 0);
    dm_op(0, 3'b010, 32'h3004, 0, r_err, r_mreq, r_be, r_mwd, r_maddr, r_rd, r_rv);
    chk("after_err_memreq", r_mreq, 1);
    chk("after_err_rvalid", r_rv, 1);

    // Starvation: both sides hammer a 1-cycle memory.
    if_req_i = 1; if_addr_i = 32'h400;
    dm_we_i = 0; dm_funct3_i = 3'b010; dm_addr_i = 32'h104; dm_req_i = 1; ns = 0;
    for (int n = 0; n < 200 && ns < 10; n++) begin
      @(negedge clk);
      if (if_gnt_o) begin seq[ns] = 1; ns++; end
      else if (dm_gnt_o) begin seq[ns] = 0; ns++; end
      @(posedge clk);
      #1;
    end
    if_req_i = 0; dm_req_i = 0;
    chk("starve_grants", ns, 10);
    for (int k = 0; k < 10; k++) chk($sformatf("starve_seq%0d", k), seq[k], (k % 5 == 4));
    repeat (4) @(posedge clk);
    #1;

    // Grant withheld for three cycles.
    gnt_pct = 0;
    dm_we_i = 0; dm_funct3_i = 3'b010; dm_addr_i = 32'h3000; dm_req_i = 1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("hold_req", mem_req_o, 1);
      chk("hold_addr", mem_addr_o, 32'h3000);
      chk("hold_nognt", dm_gnt_o, 0);
      @(posedge clk);
      #1;
    end
    gnt_pct = 100;
    @(negedge clk);
    chk("hold_gnt4", dm_gnt_o, 1);
    @(posedge clk);
    #1;
    dm_req_i = 0;
    repeat (4) @(posedge clk);
    #1;

    // Reset while the data response is outstanding.
    rsp_min = 3; rsp_max = 3; got = 0;
    dm_addr_i = 32'h108; dm_req_i = 1;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = dm_gnt_o;
      @(posedge clk);
      #1;
    end
    dm_req_i = 0;
    chk("rstmid_gnt", got, 1);
    @(posedge clk);
    #1;
    rst_n = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    seen_rv = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      seen_rv = seen_rv | dm_rvalid_o;
      @(posedge clk);
      #1;
    end
    chk("rstmid_dropped", seen_rv, 0);
    rsp_min = 0; rsp_max = 0;
    dm_op(0, 3'b010, 32'h10C, 0, r_err, r_mreq, r_be, r_mwd, r_maddr, r_rd, r_rv);
    chk("rstmid_idle_req", r_mreq, 1);

    // Randomized traffic.
    gnt_pct = 60; rsp_min = 0; rsp_max = 2;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      gi = if_gnt_o;
      gd = dm_gnt_o;
      @(posedge clk);
      #1;
      rst_n = (cyc != 1500);
      if (!if_req_i || gi) begin
        if_req_i = ($urandom_range(0, 2) != 0);
        if_addr_i = $urandom;
      end
      if (!dm_req_i || gd) begin
        dm_req_i = ($urandom_range(0, 2) != 0);
        dm_we_i = $urandom_range(0, 1);
        dm_funct3_i = 3'($urandom_range(0, 7));
        dm_addr_i = 32'h100 + $urandom_range(0, 63);
        dm_wdata_i = $urandom;
      end
    end
    if_req_i = 0; dm_req_i = 0; rst_n = 1;
    repeat (10) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
